ex_muldiv: RTL and testbench

Parametrised execute stage for the pipelined MIPS core, replacing the purely combinational logic/shift execute unit. It keeps the single-cycle logic, shift and simple-arithmetic paths. It adds architectural HI/LO registers, a single-cycle multiply, and an iterative multi-cycle divider that holds the pipeline through a stall request to the pipeline controller. It sits between the id/ex and ex/mem pipeline registers.

---
 rtl/ex_muldiv_pkg.sv | 36 +++
 rtl/ex_muldiv_if.sv | 19 +
 rtl/ex_muldiv_div.sv | 110 +++++++++++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 tb/tb_ex_muldiv.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, result classes and divider state encodings for ex_muldiv.
package ex_muldiv_pkg;
  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;

  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [2:0] EXE_RES_MOVE  = 3'd3;
  localparam logic [2:0] EXE_RES_ARITH = 3'd4;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/ex_muldiv_if.sv
// id/ex -> EX -> ex/mem signal bundle; slave side is the execute stage.
interface ex_muldiv_if #(parameter int DATA_W = 32);
  logic [7:0]        aluop_i;
  logic [2:0]        alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic              flush_i;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              stallreq_o;

  modport master (output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
                  input  wd_o, wreg_o, wdata_o, stallreq_o);
  modport slave  (input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
                  output wd_o, wreg_o, wdata_o, stallreq_o);
endinterface

// File: rtl/ex_muldiv_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle.
// Works on operand magnitudes; signs are re-applied on the outputs.
module ex_div
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              annul,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              negq_q, negq_d, negr_q, negr_d;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   shift, diff;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Next state plus one restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    a_mag   = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    b_mag   = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;
    shift   = {rem_q, quo_q[DATA_W-1]};
    diff    = shift - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (annul) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start) begin
          if (divisor == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend
            state_d = DIV_ZERO;
            quo_d   = '1;
            rem_d   = dividend;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else begin
            state_d = DIV_RUN;
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            negq_d  = signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            negr_d  = signed_op & dividend[DATA_W-1];
            cnt_d   = '0;
          end
        end
        DIV_RUN: begin
          if (diff[DATA_W]) begin
            rem_d = shift[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end else begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
        end
        DIV_ZERO: state_d = DIV_DONE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  // Outputs: hold the pipeline until DONE, then present sign-corrected results
  always_comb begin
    busy      = start & ~annul & (state_q != DIV_DONE);
    done      = (state_q == DIV_DONE);
    quotient  = negq_q ? -quo_q : quo_q;
    remainder = negr_q ? -rem_q : rem_q;
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute stage with logic/shift/arith paths, HI/LO, single-cycle
// multiply and (when EX_DIV_EN is defined) an iterative divider that stalls.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  ex
);
  localparam int SHAMT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, res;
  logic [SHAMT_W-1:0]  shamt;
  logic                mul_signed;
  logic [2*DATA_W-1:0] op1_x, op2_x, prod;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   div_quo, div_rem;

`ifdef EX_DIV_EN
  logic div_start;
  assign div_start = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_DIVU_OP);

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (ex.aluop_i == EXE_DIV_OP),
    .dividend  (ex.reg1_i),
    .divisor   (ex.reg2_i),
    .annul     (ex.flush_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  // No divider: DIV/DIVU fall through as NOPs
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign div_quo  = '0;
  assign div_rem  = '0;
`endif

  // HI/LO architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Full-width product via sign/zero extension to 2*DATA_W
  always_comb begin
    mul_signed = (ex.aluop_i == EXE_MULT_OP);
    op1_x = {{DATA_W{mul_signed & ex.reg1_i[DATA_W-1]}}, ex.reg1_i};
    op2_x = {{DATA_W{mul_signed & ex.reg2_i[DATA_W-1]}}, ex.reg2_i};
    prod  = op1_x * op2_x;
  end

  // HI/LO update for ops completing this cycle; a flushed op writes nothing
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!ex.flush_i) begin
      case (ex.aluop_i)
        EXE_MULT_OP, EXE_MULTU_OP: begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
        EXE_MTHI_OP: hi_d = ex.reg1_i;
        EXE_MTLO_OP: lo_d = ex.reg1_i;
        EXE_DIV_OP, EXE_DIVU_OP: if (div_done) begin
          hi_d = div_rem;
          lo_d = div_quo;
        end
        default: ;
      endcase
    end
  end

  // Write-back result select by result class
  always_comb begin
    res   = '0;
    shamt = ex.reg1_i[SHAMT_W-1:0];
    case (ex.alusel_i)
      EXE_RES_LOGIC: case (ex.aluop_i)
        EXE_OR_OP:  res = ex.reg1_i | ex.reg2_i;
        EXE_AND_OP: res = ex.reg1_i & ex.reg2_i;
        EXE_NOR_OP: res = ~(ex.reg1_i | ex.reg2_i);
        EXE_XOR_OP: res = ex.reg1_i ^ ex.reg2_i;
        default:    res = '0;
      endcase
      EXE_RES_SHIFT: case (ex.aluop_i)
        EXE_SLL_OP: res = ex.reg2_i << shamt;
        EXE_SRL_OP: res = ex.reg2_i >> shamt;
        EXE_SRA_OP: res = DATA_W'($signed(ex.reg2_i) >>> shamt);
        default:    res = '0;
      endcase
      EXE_RES_ARITH: case (ex.aluop_i)
        EXE_ADDU_OP: res = ex.reg1_i + ex.reg2_i;
        EXE_SUBU_OP: res = ex.reg1_i - ex.reg2_i;
        EXE_SLT_OP:  res = {{(DATA_W-1){1'b0}}, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
        EXE_SLTU_OP: res = {{(DATA_W-1){1'b0}}, ex.reg1_i < ex.reg2_i};
        default:     res = '0;
      endcase
      EXE_RES_MOVE: case (ex.aluop_i)
        EXE_MFHI_OP: res = hi_q;
        EXE_MFLO_OP: res = lo_q;
        default:     res = '0;
      endcase
      default: res = '0;
    endcase
  end

  // Output drive; reset forces quiet outputs
  always_comb begin
    ex.wd_o       = ex.wd_i;
    ex.wreg_o     = ex.wreg_i & ~ex.flush_i;
    ex.wdata_o    = rst ? '0 : res;
    ex.stallreq_o = div_busy & ~rst;
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (32-bit and 16-bit instances).
// Divider expectations follow whether EX_DIV_EN is defined in the build.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

`ifdef EX_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_W(32)) bus ();
  ex_muldiv_if #(.DATA_W(16)) bus16 ();

  ex_muldiv #(.DATA_W(32)) dut   (.clk(clk), .rst(rst), .ex(bus));
  ex_muldiv #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .ex(bus16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [2:0] s, input logic [31:0] r1, input logic [31:0] r2);
    bus.aluop_i = a; bus.alusel_i = s; bus.reg1_i = r1; bus.reg2_i = r2;
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  // Count stalled cycles of a divide already applied; ends at negedge of first free cycle
  task automatic run_div(input bit w16, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(w16 ? bus16.stallreq_o : bus.stallreq_o)) break;
      n++;
    end
  endtask

  task automatic rd_hilo(input string tag);
    op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    @(negedge clk); chk({tag, "_hi"}, bus.wdata_o, exp_hi);
    nxt;
    op(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    @(negedge clk); chk({tag, "_lo"}, bus.wdata_o, exp_lo);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.wd_i = 5'd0; bus.wreg_i = 1'b0;
    bus16.aluop_i = EXE_NOP_OP; bus16.alusel_i = EXE_RES_NOP;
    bus16.reg1_i = '0; bus16.reg2_i = '0; bus16.wd_i = 5'd0;
    bus16.wreg_i = 1'b0; bus16.flush_i = 1'b0;
    op(EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2);
    #2;
    chk("rst_wdata", bus.wdata_o, 32'h0);
    chk("rst_stall", {31'h0, bus.stallreq_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    rd_hilo("rst");

    // Single-cycle paths
    nxt; op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h000000FF);
    @(negedge clk); chk("or", bus.wdata_o, 32'h0F0F00FF);
    nxt; op(EXE_SRA_OP, EXE_RES_SHIFT, 32'h4, 32'h80000000);
    @(negedge clk); chk("sra", bus.wdata_o, 32'hF8000000);
    nxt; op(EXE_SLL_OP, EXE_RES_SHIFT, 32'h24, 32'h1);
    @(negedge clk); chk("sll_shamt", bus.wdata_o, 32'h10);
    nxt; op(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'h1);
    @(negedge clk); chk("slt", bus.wdata_o, 32'h1);
    nxt; op(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'h1);
    @(negedge clk); chk("sltu", bus.wdata_o, 32'h0);
    nxt; op(EXE_SUBU_OP, EXE_RES_ARITH, 32'h0, 32'h1);
    @(negedge clk); chk("subu", bus.wdata_o, 32'hFFFFFFFF);
    nxt; op(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'h0000FFFF);
    @(negedge clk); chk("nor", bus.wdata_o, 32'h0F0F0000);
    bus.wreg_i = 1'b1; bus.wd_i = 5'd17;
    nxt; chk("wreg", {31'h0, bus.wreg_o}, 32'h1); chk("wd", {27'h0, bus.wd_o}, 32'd17);
    bus.flush_i = 1'b1; #1;
    chk("wreg_flush", {31'h0, bus.wreg_o}, 32'h0);
    bus.flush_i = 1'b0; bus.wreg_i = 1'b0;

    // Multiply and moves
    nxt; op(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'h3);
    @(negedge clk); chk("mult_stall", {31'h0, bus.stallreq_o}, 32'h0);
    nxt; exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA; rd_hilo("mult");
    nxt; op(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'h2);
    nxt; exp_hi = 32'h1; exp_lo = 32'hFFFFFFFE; rd_hilo("multu");
    nxt; op(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234, 32'h0);
    nxt; exp_hi = 32'h1234; rd_hilo("mthi");

    // DIV -7 / 2
    nxt; op(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFFFFF9, 32'h2);
    run_div(1'b0, cyc);
    chk("div_stall", cyc, DIV_ON ? 32'd33 : 32'd0);
    chk("div_wdata", bus.wdata_o, 32'h0);
    nxt;
    if (DIV_ON) begin exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD; end
    rd_hilo("div");

    // DIVU 5 / 0
    nxt; op(EXE_DIVU_OP, EXE_RES_NOP, 32'h5, 32'h0);
    run_div(1'b0, cyc);
    chk("div0_stall", cyc, DIV_ON ? 32'd2 : 32'd0);
    nxt;
    if (DIV_ON) begin exp_hi = 32'h5; exp_lo = 32'hFFFFFFFF; end
    rd_hilo("div0");

    // Flush at RUN cycle 10: no write, stall drops, next DIV takes full latency
    nxt; op(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); chk("run9_stall", {31'h0, bus.stallreq_o}, {31'h0, DIV_ON});
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(negedge clk); chk("flush_stall", {31'h0, bus.stallreq_o}, 32'h0);
    nxt; bus.flush_i = 1'b0;
    rd_hilo("flush");
    nxt; op(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7);
    run_div(1'b0, cyc);
    chk("div_after_flush", cyc, DIV_ON ? 32'd33 : 32'd0);
    nxt;
    if (DIV_ON) begin exp_hi = 32'd2; exp_lo = 32'd14; end
    rd_hilo("div100");

    // Asynchronous reset mid-divide
    nxt; op(EXE_DIVU_OP, EXE_RES_NOP, 32'h1000, 32'h3);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("run10_stall", {31'h0, bus.stallreq_o}, {31'h0, DIV_ON});
    #1 rst = 1'b1;
    #1 chk("rst_async_stall", {31'h0, bus.stallreq_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    rd_hilo("rst_mid");
    nxt; op(EXE_DIV_OP, EXE_RES_NOP, 32'h80000000, 32'hFFFFFFFF);
    run_div(1'b0, cyc);
    chk("div_after_rst", cyc, DIV_ON ? 32'd33 : 32'd0);
    nxt;
    if (DIV_ON) begin exp_hi = 32'h0; exp_lo = 32'h80000000; end
    rd_hilo("divmin");

    // 16-bit instance: DIVU 0xFFFF / 0x0010
    nxt; op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
    bus16.aluop_i = EXE_DIVU_OP; bus16.reg1_i = 16'hFFFF; bus16.reg2_i = 16'h0010;
    run_div(1'b1, cyc);
    chk("div16_stall", cyc, DIV_ON ? 32'd17 : 32'd0);
    nxt; bus16.aluop_i = EXE_MFLO_OP; bus16.alusel_i = EXE_RES_MOVE;
    @(negedge clk); chk("div16_lo", {16'h0, bus16.wdata_o}, DIV_ON ? 32'h0FFF : 32'h0);
    nxt; bus16.aluop_i = EXE_MFHI_OP;
    @(negedge clk); chk("div16_hi", {16'h0, bus16.wdata_o}, DIV_ON ? 32'h000F : 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
